// File: rtl/seg7_capture.sv
// ----------------------------------------------------------------------------
// seg7_capture
//
// Reverse path of the multiplexed 7-segment display. The block samples the
// active-low segment bus and the active-low digit enables, and waits until
// the pair has been stable long enough to rule out glitches and ghosting
// during digit switches. It then decodes the pattern back to a BCD value and
// stores it for the digit that is currently enabled.
//
// Parameters
//   DIGITS     number of multiplexed digit positions (width of an_i), >= 1
//   STABLE_CYC consecutive identical samples needed before a commit, >= 2
//   CW         width of the stability counter; must be able to hold STABLE_CYC
//
// Ports
//   clk_i   in   1          clock, all logic on the rising edge
//   rst_i   in   1          synchronous reset, active-high, highest priority
//   seg_i   in   7          segment bus, active-low, bit6..bit0 = g..a
//   an_i    in   DIGITS     digit enables, active-low, one bit low when valid
//   clr_i   in   1          synchronous clear of the captured contents
//   dat_o   out  4*DIGITS   captured BCD, digit k at [4k+3:4k]
//   vld_o   out  DIGITS     bit k set when digit k holds a decoded 0-9
//   upd_o   out  1          one-cycle pulse on each successful commit
//   err_o   out  1          one-cycle pulse when a stable pattern is unknown
// ----------------------------------------------------------------------------
module seg7_capture #(
  parameter int DIGITS     = 4,
  parameter int STABLE_CYC = 8,
  parameter int CW         = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [6:0]            seg_i,
  input  logic [DIGITS-1:0]     an_i,
  input  logic                  clr_i,
  output logic [4*DIGITS-1:0]   dat_o,
  output logic [DIGITS-1:0]     vld_o,
  output logic                  upd_o,
  output logic                  err_o
);

  localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYC - 1);

  logic [6:0]        seg_s;
  logic [DIGITS-1:0] an_s;
  logic [CW-1:0]     cnt;

  logic       one_hot;
  logic       same;
  logic       commit;
  logic [3:0] dec_val;
  logic       dec_hit;
  logic       dec_blank;

  // The enable pattern counts as valid only with exactly one digit driven.
  // A digit switch that keeps the segment pattern still counts as a change,
  // because the enables take part in the comparison.
  always_comb begin
    one_hot = $onehot(~an_i);
    same    = ({seg_i, an_i} == {seg_s, an_s});
    commit  = one_hot && same && (cnt == CNT_LAST);
  end

  // Decode table matches what our display driver produces. Dash and blank
  // are legal "no number" patterns and are kept apart from real errors.
  always_comb begin
    dec_val   = 4'd0;
    dec_hit   = 1'b1;
    dec_blank = 1'b0;
    case (seg_i)
      7'b1000000: dec_val = 4'd0;
      7'b1111001: dec_val = 4'd1;
      7'b0100100: dec_val = 4'd2;
      7'b0110000: dec_val = 4'd3;
      7'b0011001: dec_val = 4'd4;
      7'b0010010: dec_val = 4'd5;
      7'b0000010: dec_val = 4'd6;
      7'b1111000: dec_val = 4'd7;
      7'b0000000: dec_val = 4'd8;
      7'b0011000: dec_val = 4'd9;
      7'b0111111,
      7'b1111111: begin
        dec_hit   = 1'b0;
        dec_blank = 1'b1;
      end
      default: dec_hit = 1'b0;
    endcase
  end

  // The counter saturates at STABLE_CYC, so the commit fires exactly once
  // per stable window, on the step from STABLE_CYC-1 to STABLE_CYC. Clear
  // resets the window and wins over a commit on the same edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      seg_s <= 7'h7F;
      an_s  <= '1;
      cnt   <= '0;
      dat_o <= '0;
      vld_o <= '0;
      upd_o <= 1'b0;
      err_o <= 1'b0;
    end else begin
      seg_s <= seg_i;
      an_s  <= an_i;
      upd_o <= 1'b0;
      err_o <= 1'b0;
      if (clr_i) begin
        cnt   <= '0;
        dat_o <= '0;
        vld_o <= '0;
      end else begin
        if (!one_hot) begin
          cnt <= '0;
        end else if (!same) begin
          cnt <= CW'(1);
        end else if (cnt != CNT_MAX) begin
          cnt <= cnt + CW'(1);
        end

        if (commit) begin
          for (int k = 0; k < DIGITS; k++) begin
            if (!an_i[k]) begin
              if (dec_hit) begin
                dat_o[4*k +: 4] <= dec_val;
                vld_o[k]        <= 1'b1;
              end else begin
                vld_o[k]        <= 1'b0;
              end
            end
          end
          upd_o <= dec_hit || dec_blank;
          err_o <= !(dec_hit || dec_blank);
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_capture.sv
// ----------------------------------------------------------------------------
// tb_seg7_capture
//
// Directed bench for seg7_capture. Each expected commit (or error pulse) is
// pushed into a queue when the stimulus that causes it is issued; a separate
// monitor pops an entry whenever the DUT pulses upd_o or err_o and compares
// the pulse kind together with dat_o/vld_o. A pulse with an empty queue is
// reported as unexpected; leftover entries are caught by queue-size checks.
// ----------------------------------------------------------------------------
module tb_seg7_capture;

  logic        clk_i;
  logic        rst_i;
  logic [6:0]  seg_i;
  logic [3:0]  an_i;
  logic        clr_i;
  logic [15:0] dat_o;
  logic [3:0]  vld_o;
  logic        upd_o;
  logic        err_o;

  typedef struct {
    logic        is_err;
    logic [15:0] dat;
    logic [3:0]  vld;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Segment patterns, active-low, g..a
  localparam logic [6:0] P0    = 7'b1000000;
  localparam logic [6:0] P1    = 7'b1111001;
  localparam logic [6:0] P2    = 7'b0100100;
  localparam logic [6:0] P3    = 7'b0110000;
  localparam logic [6:0] P4    = 7'b0011001;
  localparam logic [6:0] P5    = 7'b0010010;
  localparam logic [6:0] P6    = 7'b0000010;
  localparam logic [6:0] P7    = 7'b1111000;
  localparam logic [6:0] P8    = 7'b0000000;
  localparam logic [6:0] P9    = 7'b0011000;
  localparam logic [6:0] PDASH = 7'b0111111;
  localparam logic [6:0] PBLNK = 7'b1111111;
  localparam logic [6:0] PBAD  = 7'b1010101;

  localparam logic [3:0] AN0  = 4'b1110;
  localparam logic [3:0] AN1  = 4'b1101;
  localparam logic [3:0] AN2  = 4'b1011;
  localparam logic [3:0] AN3  = 4'b0111;
  localparam logic [3:0] IDLE = 4'b1111;

  seg7_capture #(
    .DIGITS    (4),
    .STABLE_CYC(8),
    .CW        (4)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .seg_i(seg_i),
    .an_i (an_i),
    .clr_i(clr_i),
    .dat_o(dat_o),
    .vld_o(vld_o),
    .upd_o(upd_o),
    .err_o(err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Single comparison point: counts every check and reports each miss.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Called on a falling edge; drives inputs and lets them be sampled by
  // 'cycles' rising edges, returning on the falling edge after the last one.
  task automatic applyStimulus(input logic [6:0] seg, input logic [3:0] an,
                               input logic clr, input int cycles);
    seg_i = seg;
    an_i  = an;
    clr_i = clr;
    repeat (cycles) @(negedge clk_i);
  endtask

  task automatic pushExp(input logic is_err, input logic [15:0] dat,
                         input logic [3:0] vld);
    exp_t e;
    e.is_err = is_err;
    e.dat    = dat;
    e.vld    = vld;
    sb.push_back(e);
  endtask

  // Monitor: samples shortly after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_i);
      #2;
      if (upd_o || err_o) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_pulse", {30'd0, upd_o, err_o}, 32'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("pulse_kind", {30'd0, upd_o, err_o},
                      {30'd0, !e.is_err, e.is_err});
          checkOutput("commit_dat", {16'd0, dat_o}, {16'd0, e.dat});
          checkOutput("commit_vld", {28'd0, vld_o}, {28'd0, e.vld});
        end
      end
    end
  end

  initial begin
    seg_i = PBLNK;
    an_i  = IDLE;
    clr_i = 1'b0;
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    checkOutput("reset_dat", {16'd0, dat_o}, 32'h0);
    checkOutput("reset_vld", {28'd0, vld_o}, 32'h0);
    checkOutput("reset_pulses", {30'd0, upd_o, err_o}, 32'h0);
    rst_i = 1'b0;

    // 1: single digit held; exactly one commit, none while saturated
    pushExp(1'b0, 16'h0002, 4'b0001);
    applyStimulus(P2, AN0, 1'b0, 8);
    checkOutput("t1_pending", sb.size(), 0);
    applyStimulus(P2, AN0, 1'b0, 20);
    checkOutput("t1_dat", {16'd0, dat_o}, 32'h0002);

    // 2: slow scan 1,9,0,7 over digits 0..3
    pushExp(1'b0, 16'h0001, 4'b0001);
    applyStimulus(P1, AN0, 1'b0, 10);
    pushExp(1'b0, 16'h0091, 4'b0011);
    applyStimulus(P9, AN1, 1'b0, 10);
    pushExp(1'b0, 16'h0091, 4'b0111);
    applyStimulus(P0, AN2, 1'b0, 10);
    pushExp(1'b0, 16'h7091, 4'b1111);
    applyStimulus(P7, AN3, 1'b0, 10);
    checkOutput("t2_pending", sb.size(), 0);
    checkOutput("t2_dat", {16'd0, dat_o}, 32'h7091);
    checkOutput("t2_vld", {28'd0, vld_o}, 32'hF);

    // 3: clear, then a scan that is too fast to commit anything
    applyStimulus(P7, AN3, 1'b1, 1);
    checkOutput("t3_clr_dat", {16'd0, dat_o}, 32'h0);
    for (int r = 0; r < 2; r++) begin
      applyStimulus(P1, AN0, 1'b0, 5);
      applyStimulus(P9, AN1, 1'b0, 5);
      applyStimulus(P0, AN2, 1'b0, 5);
      applyStimulus(P7, AN3, 1'b0, 5);
    end
    applyStimulus(PBLNK, IDLE, 1'b0, 2);
    checkOutput("t3_dat", {16'd0, dat_o}, 32'h0);
    checkOutput("t3_vld", {28'd0, vld_o}, 32'h0);

    // 4: unknown pattern on digit 1 errors, dash is a legal no-number
    pushExp(1'b0, 16'h0050, 4'b0010);
    applyStimulus(P5, AN1, 1'b0, 10);
    pushExp(1'b1, 16'h0050, 4'b0000);
    applyStimulus(PBAD, AN1, 1'b0, 10);
    pushExp(1'b0, 16'h0050, 4'b0000);
    applyStimulus(PDASH, AN1, 1'b0, 10);
    checkOutput("t4_pending", sb.size(), 0);
    checkOutput("t4_dat", {16'd0, dat_o}, 32'h0050);

    // 5: two enables low never counts; a glitch restarts the window
    applyStimulus(P4, 4'b1100, 1'b0, 20);
    applyStimulus(P4, AN2, 1'b0, 5);
    applyStimulus(PBLNK, AN2, 1'b0, 1);
    pushExp(1'b0, 16'h0450, 4'b0100);
    applyStimulus(P4, AN2, 1'b0, 7);
    checkOutput("t5_not_yet", sb.size(), 1);
    applyStimulus(P4, AN2, 1'b0, 1);
    checkOutput("t5_pending", sb.size(), 0);
    checkOutput("t5_dat", {16'd0, dat_o}, 32'h0450);

    // 6a: clear on the commit edge wins, no pulse
    applyStimulus(PBLNK, IDLE, 1'b0, 1);
    applyStimulus(P3, AN3, 1'b0, 7);
    applyStimulus(P3, AN3, 1'b1, 1);
    applyStimulus(PBLNK, IDLE, 1'b0, 2);
    checkOutput("t6_clr_dat", {16'd0, dat_o}, 32'h0);
    checkOutput("t6_clr_vld", {28'd0, vld_o}, 32'h0);

    // 6b: reset mid-window needs a full window afterwards
    pushExp(1'b0, 16'h0008, 4'b0001);
    applyStimulus(P8, AN0, 1'b0, 10);
    applyStimulus(P6, AN1, 1'b0, 5);
    rst_i = 1'b1;
    applyStimulus(P6, AN1, 1'b0, 1);
    rst_i = 1'b0;
    checkOutput("t6_rst_dat", {16'd0, dat_o}, 32'h0);
    checkOutput("t6_rst_vld", {28'd0, vld_o}, 32'h0);
    pushExp(1'b0, 16'h0060, 4'b0010);
    applyStimulus(P6, AN1, 1'b0, 7);
    checkOutput("t6_not_yet", sb.size(), 1);
    applyStimulus(P6, AN1, 1'b0, 1);
    checkOutput("t6_pending", sb.size(), 0);
    checkOutput("t6_dat", {16'd0, dat_o}, 32'h0060);

    applyStimulus(PBLNK, IDLE, 1'b0, 3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
